bsg_manycore_sdr_row_reset_sequencer: RTL and testbench
=======================================================

BSG_MANYCORE_SDR_ROW_RESET_SEQUENCER -- requirements
Module: bsg_manycore_sdr_row_reset_sequencer

Interface
REQ-001 SHALL have parameter num_links_p, default 16: number of SDR links in the row.
REQ-002 SHALL have parameter hold_width_p, default 8: width of the per-stage dwell field.
REQ-003 SHALL have parameter stagger_p, default 2 (legal >=1): cycles between successive per-link core reset releases.
REQ-004 SHALL have port core_clk_i, input, 1 bit: the single clock.
REQ-005 SHALL have port core_reset_n_i, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port cmd_v_i, input, 1 bit: sequence request valid.
REQ-007 SHALL have port cmd_ready_o, output, 1 bit: request accepted when cmd_v_i and cmd_ready_o are both high at a clock edge.
REQ-008 SHALL have port cmd_mask_i, input, num_links_p bits: link enable mask.
REQ-009 SHALL have port cmd_hold_i, input, hold_width_p bits: dwell control.
REQ-010 SHALL have port abort_i, input, 1 bit: synchronous abort.
REQ-011 SHALL have ports async_token_reset_o, async_uplink_reset_o, async_downlink_reset_o and async_downstream_reset_o, each output, num_links_p bits, active-high.
REQ-012 SHALL have port core_reset_o, output, num_links_p bits, active-high.
REQ-013 SHALL have port busy_o, output, 1 bit.
REQ-014 SHALL have port done_o, output, 1 bit: one-cycle pulse.

Function
REQ-015 SHALL capture cmd_mask_i and cmd_hold_i on acceptance and ignore both inputs until the next acceptance.
REQ-016 SHALL sequence states in order: IDLE -> ASSERT_ALL -> TOKEN -> UPLINK_REL -> DOWNLINK_REL -> DOWNSTREAM_REL -> CORE_REL -> DONE.
REQ-017 SHALL dwell exactly hold+1 cycles in each of ASSERT_ALL, TOKEN, UPLINK_REL, DOWNLINK_REL and DOWNSTREAM_REL, where hold is the captured value; hold=0 gives a 1-cycle dwell.
REQ-018 SHALL derive all outputs from registers; outputs reflect the new state from the first cycle after the edge that enters that state.
REQ-019 SHALL drive per enabled link in ASSERT_ALL: uplink=downlink=downstream=1, token=0, core=1.
REQ-020 SHALL set token=1 in TOKEN and return it to 0 in every later state.
REQ-021 SHALL deassert uplink in UPLINK_REL, downlink in DOWNLINK_REL and downstream in DOWNSTREAM_REL; each stays deasserted through DONE.
REQ-022 SHALL, in CORE_REL, release core_reset_o[num_links_p-1] in the first cycle, then release link x stagger_p cycles after link x+1 (highest index first).
REQ-023 SHALL spend exactly (num_links_p-1)*stagger_p+1 cycles in CORE_REL, then enter DONE.
REQ-024 SHALL hold every reset output of a masked-off link (mask bit 0) at 1 throughout the sequence, except token, which is held at 0.
REQ-025 SHALL still time a masked slot in CORE_REL, so the sequence length is independent of the mask.
REQ-026 SHALL pulse done_o for exactly one cycle, the cycle in which DONE is entered.
REQ-027 SHALL remain in DONE with the released values held until the next acceptance or abort_i.
REQ-028 SHALL drive cmd_ready_o=1 only in IDLE and DONE.
REQ-029 SHALL drive busy_o=1 in every state other than IDLE and DONE.
REQ-030 SHALL, on acceptance in DONE, re-enter ASSERT_ALL and reassert the released resets in the next cycle.
REQ-031 SHALL, on abort_i=1 in any state, enter IDLE at the next edge with all resets for all links driven as ASSERT_ALL values, clear the counters, and not pulse done_o.
REQ-032 SHALL give abort_i priority over a simultaneous acceptance; the request is dropped.
REQ-033 SHALL accept a request in the cycle abort_i deasserts if cmd_v_i=1.
REQ-034 SHALL use a hold counter of hold_width_p+1 bits so the dwell count does not wrap at hold = 2^hold_width_p-1.
REQ-035 SHALL use a stagger counter sized to $clog2((num_links_p-1)*stagger_p+1) and SHALL NOT wrap within CORE_REL.

Reset
REQ-036 SHALL, while core_reset_n_i=0, immediately (asynchronously) force: state IDLE; uplink, downlink, downstream and core all 1 for every link; token 0; busy_o=0; done_o=0; cmd_ready_o=0; captured mask cleared to all zeros; counters zero.
REQ-037 SHALL raise cmd_ready_o in the first cycle after core_reset_n_i deasserts.
REQ-038 SHALL, on core_reset_n_i assertion mid-sequence, discard the sequence with no done_o pulse.

Verification
REQ-039 SHALL cover (num_links_p=4, stagger_p=2) mask=4'hF, hold=2 -> token high 3 cycles; uplink, downlink and downstream fall 3 cycles apart; core_reset_o falls in order 3,2,1,0, 2 cycles apart; done_o pulses once after 22 busy cycles.
REQ-040 SHALL cover mask=4'b0101, hold=0 -> links 1 and 3 keep uplink, downlink, downstream and core at 1 and token at 0; links 0 and 2 complete the sequence; done_o occurs after the same 12 busy cycles as with mask=4'hF.
REQ-041 SHALL cover hold=8'hFF -> each dwell is exactly 256 cycles with no wrap; CORE_REL is 7 cycles.
REQ-042 SHALL cover abort_i pulsed in DOWNLINK_REL -> next cycle all outputs equal ASSERT_ALL values, busy_o=0, cmd_ready_o=1, no done_o pulse.
REQ-043 SHALL cover core_reset_n_i asserted in CORE_REL -> outputs forced to reset values before the next edge; after release, a new request completes normally.
REQ-044 SHALL cover a request accepted in DONE, with abort_i and cmd_v_i both high in the same cycle -> the request is re-run in the first case; in the second, abort wins and the state is IDLE.

Source files
------------

// File: rtl/bsg_manycore_sdr_row_reset_sequencer.sv
// Row-level SDR reset sequencer: walks every enabled link through a full reset assertion,
// a token pulse, staged link releases and a staggered core release, then reports done.
module bsg_manycore_sdr_row_reset_sequencer #(
  parameter int num_links_p  = 16,
  parameter int hold_width_p = 8,
  parameter int stagger_p    = 2
) (
  input  logic                    core_clk_i,
  input  logic                    core_reset_n_i,
  input  logic                    cmd_v_i,
  output logic                    cmd_ready_o,
  input  logic [num_links_p-1:0]  cmd_mask_i,
  input  logic [hold_width_p-1:0] cmd_hold_i,
  input  logic                    abort_i,
  output logic [num_links_p-1:0]  async_token_reset_o,
  output logic [num_links_p-1:0]  async_uplink_reset_o,
  output logic [num_links_p-1:0]  async_downlink_reset_o,
  output logic [num_links_p-1:0]  async_downstream_reset_o,
  output logic [num_links_p-1:0]  core_reset_o,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam int core_cycles_lp = (num_links_p - 1) * stagger_p + 1;
  localparam int stag_width_lp  = (core_cycles_lp > 1) ? $clog2(core_cycles_lp) : 1;
  localparam logic [stag_width_lp-1:0] stag_last_lp = stag_width_lp'(core_cycles_lp - 1);
  localparam logic [stag_width_lp-1:0] stag_inc_lp  = {{(stag_width_lp-1){1'b0}}, 1'b1};
  localparam logic [hold_width_p:0]    hold_inc_lp  = {{hold_width_p{1'b0}}, 1'b1};
  localparam logic [num_links_p-1:0]   ones_lp      = {num_links_p{1'b1}};
  localparam logic [num_links_p-1:0]   zeros_lp     = {num_links_p{1'b0}};

  // Encoding is consecutive so each dwell stage advances by one.
  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    ASSERT_ALL     = 3'd1,
    TOKEN          = 3'd2,
    UPLINK_REL     = 3'd3,
    DOWNLINK_REL   = 3'd4,
    DOWNSTREAM_REL = 3'd5,
    CORE_REL       = 3'd6,
    DONE           = 3'd7
  } state_e;

  state_e                  state_r, next_state_s;
  logic [hold_width_p:0]   hold_cnt_r, next_hold_cnt_s;
  logic [stag_width_lp-1:0] stag_cnt_r, next_stag_cnt_s;
  logic [num_links_p-1:0]  mask_r, next_mask_s;
  logic [hold_width_p-1:0] hold_r, next_hold_s;
  logic [num_links_p-1:0]  next_token_s, next_uplink_s, next_downlink_s;
  logic [num_links_p-1:0]  next_downstream_s, next_core_s;
  logic                    next_ready_s, next_busy_s, next_done_s;
  logic                    accept_s, hold_done_s, stag_done_s;

  // Next-state, counters and the output image of the state being entered.
  always_comb begin
    accept_s        = cmd_v_i & cmd_ready_o & ~abort_i;
    hold_done_s     = (hold_cnt_r == {1'b0, hold_r});
    stag_done_s     = (stag_cnt_r == stag_last_lp);
    next_state_s    = state_r;
    next_hold_cnt_s = {(hold_width_p+1){1'b0}};
    next_stag_cnt_s = {stag_width_lp{1'b0}};
    next_mask_s     = mask_r;
    next_hold_s     = hold_r;

    if (abort_i) begin
      next_state_s = IDLE;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (accept_s) begin
            next_state_s = ASSERT_ALL;
            next_mask_s  = cmd_mask_i;
            next_hold_s  = cmd_hold_i;
          end else begin
            next_state_s = state_r;
          end
        end
        ASSERT_ALL, TOKEN, UPLINK_REL, DOWNLINK_REL, DOWNSTREAM_REL: begin
          if (hold_done_s) begin
            next_state_s = state_e'(state_r + 3'd1);
          end else begin
            next_hold_cnt_s = hold_cnt_r + hold_inc_lp;
          end
        end
        CORE_REL: begin
          if (stag_done_s) begin
            next_state_s = DONE;
          end else begin
            next_stag_cnt_s = stag_cnt_r + stag_inc_lp;
          end
        end
        default: next_state_s = IDLE;
      endcase
    end

    next_ready_s      = (next_state_s == IDLE) || (next_state_s == DONE);
    next_busy_s       = ~next_ready_s;
    next_done_s       = (next_state_s == DONE) && (state_r != DONE);
    next_token_s      = zeros_lp;
    next_uplink_s     = ones_lp;
    next_downlink_s   = ones_lp;
    next_downstream_s = ones_lp;
    next_core_s       = ones_lp;

    // Masked-off links, and every link while idle, keep the fully asserted image.
    for (int i = 0; i < num_links_p; i++) begin
      case (next_mask_s[i] ? next_state_s : IDLE)
        TOKEN: next_token_s[i] = 1'b1;
        UPLINK_REL: next_uplink_s[i] = 1'b0;
        DOWNLINK_REL: begin
          next_uplink_s[i]   = 1'b0;
          next_downlink_s[i] = 1'b0;
        end
        DOWNSTREAM_REL: begin
          next_uplink_s[i]     = 1'b0;
          next_downlink_s[i]   = 1'b0;
          next_downstream_s[i] = 1'b0;
        end
        CORE_REL: begin
          next_uplink_s[i]     = 1'b0;
          next_downlink_s[i]   = 1'b0;
          next_downstream_s[i] = 1'b0;
          // Highest link releases at count 0, each lower link stagger_p counts later.
          next_core_s[i] = (next_stag_cnt_s < stag_width_lp'((num_links_p - 1 - i) * stagger_p));
        end
        DONE: begin
          next_uplink_s[i]     = 1'b0;
          next_downlink_s[i]   = 1'b0;
          next_downstream_s[i] = 1'b0;
          next_core_s[i]       = 1'b0;
        end
        default: next_token_s[i] = 1'b0;
      endcase
    end
  end

  // State, counters, captured command and registered outputs.
  always_ff @(posedge core_clk_i or negedge core_reset_n_i) begin
    if (!core_reset_n_i) begin
      state_r                  <= IDLE;
      hold_cnt_r               <= {(hold_width_p+1){1'b0}};
      stag_cnt_r               <= {stag_width_lp{1'b0}};
      mask_r                   <= zeros_lp;
      hold_r                   <= {hold_width_p{1'b0}};
      async_token_reset_o      <= zeros_lp;
      async_uplink_reset_o     <= ones_lp;
      async_downlink_reset_o   <= ones_lp;
      async_downstream_reset_o <= ones_lp;
      core_reset_o             <= ones_lp;
      cmd_ready_o              <= 1'b0;
      busy_o                   <= 1'b0;
      done_o                   <= 1'b0;
    end else begin
      state_r                  <= next_state_s;
      hold_cnt_r               <= next_hold_cnt_s;
      stag_cnt_r               <= next_stag_cnt_s;
      mask_r                   <= next_mask_s;
      hold_r                   <= next_hold_s;
      async_token_reset_o      <= next_token_s;
      async_uplink_reset_o     <= next_uplink_s;
      async_downlink_reset_o   <= next_downlink_s;
      async_downstream_reset_o <= next_downstream_s;
      core_reset_o             <= next_core_s;
      cmd_ready_o              <= next_ready_s;
      busy_o                   <= next_busy_s;
      done_o                   <= next_done_s;
    end
  end

endmodule

// File: tb/tb_bsg_manycore_sdr_row_reset_sequencer.sv
// Scoreboarded bench for the row reset sequencer (4 links, stagger 2): the stimulus queues
// expected output images per cycle, a monitor compares them on the falling edge.
module tb_bsg_manycore_sdr_row_reset_sequencer;

  localparam logic [3:0] ALL = 4'hF;
  localparam int         BIG = 100000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_v = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] cmd_mask = 4'h0;
  logic [7:0] cmd_hold = 8'h00;
  logic       cmd_ready, busy, done;
  logic [3:0] tok, up, dn, ds, core;

  bsg_manycore_sdr_row_reset_sequencer #(
    .num_links_p(4), .hold_width_p(8), .stagger_p(2)
  ) dut (
    .core_clk_i(clk), .core_reset_n_i(rst_n), .cmd_v_i(cmd_v), .cmd_ready_o(cmd_ready),
    .cmd_mask_i(cmd_mask), .cmd_hold_i(cmd_hold), .abort_i(abort),
    .async_token_reset_o(tok), .async_uplink_reset_o(up), .async_downlink_reset_o(dn),
    .async_downstream_reset_o(ds), .core_reset_o(core), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    int         kind;   // 0: output image, 1: done pulse count
    string      name;
    logic [3:0] tok, up, dn, ds, core;
    logic       busy, ready, done;
    int         cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0, failures = 0, done_cnt = 0;
  bit   stim_done = 1'b0;

  // Core links released so far, by cycle within CORE_REL (3 first, 2 cycles apart).
  logic [3:0] rel_tbl [7] = '{4'b1000, 4'b1000, 4'b1100, 4'b1100, 4'b1110, 4'b1110, 4'b1111};

  task automatic push(input int c, input string nm, input logic [3:0] et, eu, ed, es, ec,
                      input logic eb, er, edn);
    exp_t e;
    e.cyc = c; e.kind = 0; e.name = nm; e.tok = et; e.up = eu; e.dn = ed; e.ds = es;
    e.core = ec; e.busy = eb; e.ready = er; e.done = edn; e.cnt = 0;
    q.push_back(e);
  endtask

  task automatic push_cnt(input int c, input int n);
    exp_t e;
    e.cyc = c; e.kind = 1; e.name = "done_count"; e.tok = 4'h0; e.up = 4'h0; e.dn = 4'h0;
    e.ds = 4'h0; e.core = 4'h0; e.busy = 1'b0; e.ready = 1'b0; e.done = 1'b0; e.cnt = n;
    q.push_back(e);
  endtask

  task automatic push_idle(input int c, input string nm);
    push(c, nm, 4'h0, ALL, ALL, ALL, ALL, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic push_rst(input int c, input string nm);
    push(c, nm, 4'h0, ALL, ALL, ALL, ALL, 1'b0, 1'b0, 1'b0);
  endtask

  // Expected timeline of one sequence accepted at edge a; entries beyond upto are skipped.
  task automatic push_seq(input int a, input logic [3:0] m, input int h, input int upto,
                          output int d);
    int dw = h + 1;
    int c0 = a + 5 * dw;
    logic [3:0] nm = ~m;
    for (int st = 0; st < 5; st++) begin
      int f = a + st * dw;
      logic [3:0] et = (st == 1) ? m : 4'h0;
      logic [3:0] eu = (st >= 2) ? nm : ALL;
      logic [3:0] ed = (st >= 3) ? nm : ALL;
      logic [3:0] es = (st >= 4) ? nm : ALL;
      if (f <= upto) push(f, "stage_first", et, eu, ed, es, ALL, 1'b1, 1'b0, 1'b0);
      if (f + dw - 1 <= upto) push(f + dw - 1, "stage_last", et, eu, ed, es, ALL, 1'b1, 1'b0, 1'b0);
    end
    for (int j = 0; j < 7; j++) begin
      if (c0 + j <= upto) push(c0 + j, "core_rel", 4'h0, nm, nm, nm, ~(rel_tbl[j] & m), 1'b1, 1'b0, 1'b0);
    end
    d = c0 + 7;
    if (d <= upto) push(d, "done_pulse", 4'h0, nm, nm, nm, nm, 1'b0, 1'b1, 1'b1);
    if (d + 1 <= upto) push(d + 1, "done_hold", 4'h0, nm, nm, nm, nm, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Called on a falling edge while the DUT is ready; acceptance happens at edge a.
  task automatic start(input logic [3:0] m, input logic [7:0] h, input int lim,
                       output int a, output int d);
    cmd_v = 1'b1; cmd_mask = m; cmd_hold = h;
    a = cyc + 1;
    push_seq(a, m, int'(h), a + lim, d);
    @(negedge clk);
    cmd_v = 1'b0; cmd_mask = ~m; cmd_hold = h ^ 8'h5A;
  endtask

  // Monitor: pops every expectation due this cycle and compares.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        checks++;
        if (e.cyc < cyc) begin
          failures++;
          $display("FAIL %s: expectation for cyc %0d not reached in time (now %0d)", e.name, e.cyc, cyc);
        end else if (e.kind == 1) begin
          if (done_cnt != e.cnt) begin
            failures++;
            $display("FAIL %s cyc=%0d: got %0d pulses, want %0d", e.name, cyc, done_cnt, e.cnt);
          end
        end else if ({tok, up, dn, ds, core, busy, cmd_ready, done} !==
                     {e.tok, e.up, e.dn, e.ds, e.core, e.busy, e.ready, e.done}) begin
          failures++;
          $display("FAIL %s cyc=%0d: got tok=%h up=%h dn=%h ds=%h core=%h busy=%b ready=%b done=%b, want tok=%h up=%h dn=%h ds=%h core=%h busy=%b ready=%b done=%b",
                   e.name, cyc, tok, up, dn, ds, core, busy, cmd_ready, done,
                   e.tok, e.up, e.dn, e.ds, e.core, e.busy, e.ready, e.done);
        end
      end
      if (stim_done || cyc > 4000) begin
        checks++;
        if (!stim_done || q.size() != 0) begin
          failures++;
          $display("FAIL end_of_run: stim_done=%0d pending=%0d, want stim_done=1 pending=0", stim_done, q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    end
  end

  // Directed scenarios.
  initial begin
    int a, d, a2, d2;
    push_rst(1, "in_reset");
    push_rst(2, "in_reset");
    push_rst(3, "in_reset");
    push_idle(4, "ready_after_reset");
    wait_cyc(3);
    #2 rst_n = 1'b1;
    wait_cyc(5);

    // Full mask, hold 2: 22 busy cycles.
    start(ALL, 8'd2, BIG, a, d);
    push_cnt(d + 1, 1);
    wait_cyc(d + 1);

    // Partial mask, hold 0: 12 busy cycles, masked links stay asserted.
    start(4'b0101, 8'd0, 12, a, d);
    push_cnt(d, 2);
    wait_cyc(d);

    // New request accepted straight out of DONE.
    start(ALL, 8'd0, 12, a2, d2);
    push_cnt(d2, 3);
    wait_cyc(d2);

    // Abort and request together in DONE: abort wins.
    abort = 1'b1; cmd_v = 1'b1; cmd_mask = ALL; cmd_hold = 8'd0;
    push_idle(d2 + 1, "abort_beats_accept");
    push_idle(d2 + 2, "abort_stays_idle");
    @(negedge clk);
    abort = 1'b0; cmd_v = 1'b0;
    wait_cyc(d2 + 2);

    // Abort during DOWNLINK_REL, then accept as abort drops.
    start(ALL, 8'd2, 9, a, d);
    wait_cyc(a + 9);
    abort = 1'b1;
    push_idle(a + 10, "abort_in_downlink");
    @(negedge clk);
    abort = 1'b0;
    start(4'hA, 8'd1, BIG, a, d);
    push_cnt(d + 1, 4);
    wait_cyc(d + 1);

    // Maximum hold: 256-cycle dwells.
    start(ALL, 8'hFF, BIG, a, d);
    push_cnt(d + 1, 5);
    wait_cyc(d + 1);

    // Asynchronous reset in CORE_REL, then a fresh sequence.
    start(ALL, 8'd0, 7, a, d);
    push_rst(a + 8, "reset_mid_core_rel");
    push_rst(a + 9, "reset_mid_core_rel");
    push_idle(a + 10, "ready_after_mid_reset");
    push_cnt(a + 10, 5);
    wait_cyc(a + 7);
    @(posedge clk);
    #2 rst_n = 1'b0;
    wait_cyc(a + 9);
    #2 rst_n = 1'b1;
    wait_cyc(a + 10);
    start(4'h3, 8'd1, BIG, a, d);
    push_cnt(d + 1, 6);
    wait_cyc(d + 2);
    stim_done = 1'b1;
  end

endmodule
